alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// At most one operation is in flight; its result is held until the consumer takes it.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_z,
  input  logic             alu_ex,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             rsp_id
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, z_q, z_d;
  logic [2:0]       op_q, op_d;

  logic             gnt;
  logic             acc;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [2:0]       sel_op;

  function automatic logic op_legal(input logic [2:0] op);
    return op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
  endfunction

  // Contested cycle goes to whoever did not win last; a lone requester always wins.
  assign gnt    = (req0_valid & req1_valid) ? ~last_q : req1_valid;
  assign sel_a  = gnt ? req1_a  : req0_a;
  assign sel_b  = gnt ? req1_b  : req0_b;
  assign sel_op = gnt ? req1_op : req0_op;
  assign acc    = (state_q == IDLE) & (gnt ? req1_valid : req0_valid);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    z_d        = z_q;
    zero_d     = zero_q;
    err_d      = err_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = '0;
    rsp_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = acc & ~gnt;
        req1_ready = acc &  gnt;
        if (acc) begin
          a_d    = sel_a;
          b_d    = sel_b;
          op_d   = sel_op;
          id_d   = gnt;
          last_d = gnt;
          // Illegal ops never reach the ALU; the error response is built here.
          if (op_legal(sel_op)) begin
            state_d = ISSUE;
          end else begin
            state_d = RESP;
            z_d     = '0;
            zero_d  = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      ISSUE: begin
        alu_a   = a_q;
        alu_b   = b_q;
        alu_op  = op_q;
        z_d     = alu_z;
        zero_d  = alu_ex;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign rsp_z    = z_q;
  assign rsp_zero = zero_q;
  assign rsp_err  = err_q;
  assign rsp_id   = id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: the bench plays the shared ALU and tracks each transaction
// with a small in-flight model (busy flag + cycles-to-response) for per-cycle checks.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] alu_a, alu_b, alu_z;
  logic [2:0]   alu_op;
  logic         alu_ex;
  logic         rsp_valid, rsp_ready, rsp_zero, rsp_err, rsp_id;
  logic [W-1:0] rsp_z;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z), .alu_ex(alu_ex),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err), .rsp_id(rsp_id)
  );

  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  function automatic bit legal(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b001) || (op == 3'b010) || (op == 3'b110) || (op == 3'b111);
  endfunction

  // Environment ALU
  assign alu_z  = alu_fn(alu_a, alu_b, alu_op);
  assign alu_ex = (alu_z == '0);

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model
  bit           m_busy, m_last, m_id, m_zero, m_err;
  int           m_delay;
  logic [W-1:0] m_a, m_b, m_z;
  logic [2:0]   m_op;
  bit           e0, e1, e_done;
  bit           ids[$];

  task automatic model_reset();
    m_busy = 0; m_last = 1; m_delay = 0;
  endtask

  task automatic check_all();
    bit ev, iss;
    e0 = !m_busy && req0_valid && (!req1_valid || m_last);
    e1 = !m_busy && req1_valid && (!req0_valid || !m_last);
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    ev  = m_busy && (m_delay == 0);
    iss = m_busy && (m_delay == 1);
    chk("rsp_valid", rsp_valid, ev);
    if (ev) begin
      chk("rsp_z", rsp_z, m_z);
      chk("rsp_zero", rsp_zero, m_zero);
      chk("rsp_err", rsp_err, m_err);
      chk("rsp_id", rsp_id, m_id);
      if (rsp_ready) ids.push_back(rsp_id);
    end
    chk("alu_a", alu_a, iss ? m_a : '0);
    chk("alu_b", alu_b, iss ? m_b : '0);
    chk("alu_op", alu_op, iss ? m_op : 3'b0);
    e_done = ev && rsp_ready;
  endtask

  task automatic model_update();
    if (m_busy) begin
      if (m_delay == 1) m_delay = 0;
      else if (e_done) m_busy = 0;
    end else if (e0 || e1) begin
      m_id   = e1;
      m_last = e1;
      m_a    = e1 ? req1_a  : req0_a;
      m_b    = e1 ? req1_b  : req0_b;
      m_op   = e1 ? req1_op : req0_op;
      m_busy = 1;
      m_delay = legal(m_op) ? 1 : 0;
      m_z    = legal(m_op) ? alu_fn(m_a, m_b, m_op) : '0;
      m_zero = legal(m_op) && (m_z == '0);
      m_err  = !legal(m_op);
    end
  endtask

  // Inputs are set just after a rising edge; check on the falling edge, then advance.
  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_req(input int n, input bit v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    if (n == 0) begin req0_valid = v; req0_a = a; req0_b = b; req0_op = op; end
    else        begin req1_valid = v; req1_a = a; req1_b = b; req1_op = op; end
  endtask

  task automatic drain();
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_rdy0"}, req0_ready, 0);
    chk({tag, "_rdy1"}, req1_ready, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_op"}, alu_op, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_z"}, rsp_z, 0);
    chk({tag, "_rsp_zero"}, rsp_zero, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
  endtask

  initial begin
    rst_n = 0; rsp_ready = 0;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    model_reset();
    #3;
    check_zero_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;

    // add on requester 0: 5+3
    set_req(0, 1, 32'd5, 32'd3, 3'b010); rsp_ready = 1;
    step();
    req0_valid = 0;
    chk("d031_issue_valid", rsp_valid, 0);
    step();
    chk("d031_valid", rsp_valid, 1);
    chk("d031_z", rsp_z, 32'd8);
    chk("d031_zero", rsp_zero, 0);
    chk("d031_id", rsp_id, 0);
    drain();

    // sub on requester 1: 7-7
    set_req(1, 1, 32'd7, 32'd7, 3'b110);
    step(); req1_valid = 0; step();
    chk("d032_z", rsp_z, 32'd0);
    chk("d032_zero", rsp_zero, 1);
    chk("d032_id", rsp_id, 1);
    chk("d032_err", rsp_err, 0);
    drain();

    // both valid continuously: alternation
    ids.delete();
    set_req(0, 1, 32'd10, 32'd4, 3'b001);
    set_req(1, 1, 32'd9, 32'd2, 3'b000);
    for (int i = 0; i < 12; i++) step();
    chk("d033_count", ids.size() >= 4, 1);
    if (ids.size() >= 4) begin
      chk("d033_id0", ids[0], 0);
      chk("d033_id1", ids[1], 1);
      chk("d033_id2", ids[2], 0);
      chk("d033_id3", ids[3], 1);
    end
    drain();

    // illegal op
    set_req(0, 1, 32'd1, 32'd2, 3'b011);
    step(); req0_valid = 0;
    chk("d034_valid", rsp_valid, 1);
    chk("d034_err", rsp_err, 1);
    chk("d034_z", rsp_z, 0);
    chk("d034_alu_op", alu_op, 0);
    drain();

    // consumer stall while both requesters wait
    rsp_ready = 0;
    set_req(1, 1, 32'hFFFF_FFFF, 32'd1, 3'b111);
    set_req(0, 1, 32'd3, 32'd3, 3'b010);
    step(); step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("d035_rdy0", req0_ready, 0);
      chk("d035_rdy1", req1_ready, 0);
    end
    drain();

    // reset during ISSUE
    set_req(0, 1, 32'd5, 32'd6, 3'b010);
    set_req(1, 1, 32'd8, 32'd1, 3'b110);
    step();
    set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0);
    chk("d036_in_issue", alu_op, legal(m_op) ? m_op : 3'b0);
    rst_n = 0;
    #1;
    check_zero_outputs("d036");
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) step();
    set_req(0, 1, 32'd2, 32'd2, 3'b000);
    set_req(1, 1, 32'd4, 32'd4, 3'b000);
    #1;
    chk("d036_rdy0", req0_ready, 1);
    chk("d036_rdy1", req1_ready, 0);
    step();
    drain();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 2; n++) begin
        logic [W-1:0] a, b;
        a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
        b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
        set_req(n, $urandom_range(0, 9) < 7, a, b, 3'($urandom_range(0, 7)));
      end
      rsp_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
